ps2_receiver: RTL and testbench

PS2_RECEIVER -- requirements
Module: ps2_receiver

---
 rtl/ps2_receiver.sv | 183 ++++++++++++++++++
 tb/tb_ps2_receiver.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the raw lines, then
// decodes 11-bit frames into scan codes with parity, stop-bit and timeout checks.
module ps2_receiver #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] scanCode,
  output logic       scanCodeReady,
  output logic       parityError,
  output logic       frameError,
  output logic       busy
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic [1:0]    clk_sync_r;
  logic [1:0]    data_sync_r;
  logic [1:0]    sync_lvl_s;
  logic [1:0]    filt_r;
  logic [FW-1:0] filt_cnt_r [2];
  logic          prev_clk_r;
  logic          fall_s;
  logic          data_s;

  state_t        state_r, state_n;
  logic [2:0]    bit_cnt_r, bit_cnt_n;
  logic [7:0]    shift_r, shift_n;
  logic          par_r, par_n;
  logic [TW-1:0] tmo_r, tmo_n;
  logic          timeout_s;
  logic [7:0]    code_n;
  logic          ready_n, perr_n, ferr_n, busy_n;

  // Odd parity over the eight data bits plus the received parity bit.
  function automatic logic odd_parity(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // Two-flop synchronizers; reset to the idle-high bus level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2Clk};
      data_sync_r <= {data_sync_r[0], ps2Data};
    end
  end

  assign sync_lvl_s = {clk_sync_r[1], data_sync_r[1]};

  // Per-line deglitch filter; index 1 is ps2Clk, index 0 is ps2Data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_r     <= 2'b11;
      prev_clk_r <= 1'b1;
      for (int i = 0; i < 2; i++) filt_cnt_r[i] <= '0;
    end else begin
      prev_clk_r <= filt_r[1];
      for (int i = 0; i < 2; i++) begin
        if (sync_lvl_s[i] == filt_r[i]) begin
          filt_cnt_r[i] <= '0;
        end else if (filt_cnt_r[i] == FW'(FILTER_LEN - 1)) begin
          filt_r[i]     <= sync_lvl_s[i];
          filt_cnt_r[i] <= '0;
        end else begin
          filt_cnt_r[i] <= filt_cnt_r[i] + 1'b1;
        end
      end
    end
  end

  assign fall_s    = prev_clk_r & ~filt_r[1];
  assign data_s    = filt_r[0];
  // An edge arriving together with the timeout is swallowed by the timeout.
  assign timeout_s = (state_r != IDLE) && (tmo_r == TW'(TIMEOUT_CYCLES - 1));

  // Frame decoder next-state and output logic.
  always_comb begin
    state_n   = state_r;
    bit_cnt_n = bit_cnt_r;
    shift_n   = shift_r;
    par_n     = par_r;
    code_n    = scanCode;
    ready_n   = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;
    if (timeout_s) begin
      state_n = IDLE;
      ferr_n  = 1'b1;
    end else if (fall_s) begin
      case (state_r)
        IDLE: begin
          if (!data_s) begin
            state_n   = DATA;
            bit_cnt_n = 3'd0;
          end else begin
            state_n = IDLE;
          end
        end
        DATA: begin
          shift_n   = {data_s, shift_r[7:1]};
          bit_cnt_n = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_n = PARITY;
          end else begin
            state_n = DATA;
          end
        end
        PARITY: begin
          par_n   = data_s;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (!data_s) begin
            ferr_n = 1'b1;
          end else if (odd_parity(shift_r, par_r)) begin
            code_n  = shift_r;
            ready_n = 1'b1;
          end else begin
            perr_n = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end else begin
      state_n = state_r;
    end
    busy_n = (state_n != IDLE);
  end

  // Inactivity timer: cleared by any falling edge and whenever idle.
  always_comb begin
    if ((state_r == IDLE) || fall_s || timeout_s) begin
      tmo_n = '0;
    end else begin
      tmo_n = tmo_r + 1'b1;
    end
  end

  // Decoder state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      bit_cnt_r     <= 3'd0;
      shift_r       <= 8'h00;
      par_r         <= 1'b0;
      tmo_r         <= '0;
      scanCode      <= 8'h00;
      scanCodeReady <= 1'b0;
      parityError   <= 1'b0;
      frameError    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_r       <= state_n;
      bit_cnt_r     <= bit_cnt_n;
      shift_r       <= shift_n;
      par_r         <= par_n;
      tmo_r         <= tmo_n;
      scanCode      <= code_n;
      scanCodeReady <= ready_n;
      parityError   <= perr_n;
      frameError    <= ferr_n;
      busy          <= busy_n;
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench for ps2_receiver: directed frames push expected events,
// a monitor pops and compares on every output pulse.
module tb_ps2_receiver;

  localparam int TIMEOUT_CYCLES = 5000;
  localparam logic [2:0] K_READY = 3'b100;
  localparam logic [2:0] K_PERR  = 3'b010;
  localparam logic [2:0] K_FERR  = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [7:0] scanCode;
  logic       scanCodeReady, parityError, frameError, busy;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] code;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  ps2_receiver #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst), .ps2Clk(ps2Clk), .ps2Data(ps2Data),
    .scanCode(scanCode), .scanCodeReady(scanCodeReady),
    .parityError(parityError), .frameError(frameError), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: every pulse cycle must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (scanCodeReady || parityError || frameError) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got {rdy,perr,ferr}=%b code=%h, required no pulse",
                 {scanCodeReady, parityError, frameError}, scanCode);
      end else begin
        e = q.pop_front();
        if ({scanCodeReady, parityError, frameError} !== e.kind || scanCode !== e.code) begin
          fails++;
          $display("FAIL pulse: got {rdy,perr,ferr}=%b code=%h, required %b code=%h",
                   {scanCodeReady, parityError, frameError}, scanCode, e.kind, e.code);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input logic [2:0] kind, input logic [7:0] code);
    exp_t e;
    e.kind = kind;
    e.code = code;
    q.push_back(e);
  endtask

  // Drive n frame bits (bit 0 first), each with a 20-cycle low clock phase.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2Data = bits[i];
      clks(10);
      ps2Clk = 1'b0;
      clks(20);
      ps2Clk = 1'b1;
      clks(10);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bits({stop, par, d, 1'b0}, 11);
    ps2Data = 1'b1;
    clks(20);
  endtask

  initial begin
    logic saw_busy;
    clks(3);
    check("reset_scancode", {24'h0, scanCode}, 32'h00);
    check("reset_pulses", {29'h0, scanCodeReady, parityError, frameError}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    clks(10);
    check("idle_after_release", {31'h0, busy}, 32'h0);

    expect_ev(K_READY, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1);
    expect_ev(K_READY, 8'hF0);
    send_frame(8'hF0, 1'b1, 1'b1);
    expect_ev(K_READY, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1);
    expect_ev(K_PERR, 8'h1C);
    send_frame(8'h75, 1'b1, 1'b1);
    check("scancode_held_after_perr", {24'h0, scanCode}, 32'h1C);
    expect_ev(K_READY, 8'hE0);
    send_frame(8'hE0, 1'b0, 1'b1);
    expect_ev(K_FERR, 8'hE0);
    send_frame(8'h75, 1'b0, 1'b0);
    check("scancode_held_after_ferr", {24'h0, scanCode}, 32'hE0);

    // Short clock glitch with data low must not start a frame.
    ps2Data = 1'b0;
    clks(10);
    ps2Clk = 1'b0;
    clks(2);
    ps2Clk = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      clks(1);
      saw_busy = saw_busy | busy;
    end
    check("glitch_busy", {31'h0, saw_busy}, 32'h0);
    ps2Data = 1'b1;
    clks(20);

    // Partial frame (start + 3 data bits) abandoned by the timeout.
    send_bits(11'b000_0000_1010, 4);
    check("partial_busy", {31'h0, busy}, 32'h1);
    expect_ev(K_FERR, 8'hE0);
    clks(TIMEOUT_CYCLES + 100);
    check("timeout_busy", {31'h0, busy}, 32'h0);
    expect_ev(K_READY, 8'h75);
    send_frame(8'h75, 1'b0, 1'b1);

    // Reset in the middle of a frame after five data bits.
    send_bits(11'b000_0001_0110, 6);
    check("midframe_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    clks(3);
    check("midrst_scancode", {24'h0, scanCode}, 32'h00);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    ps2Data = 1'b1;
    clks(20);
    check("midrst_outputs", {24'h0, scanCode, 5'h0, scanCodeReady, parityError, frameError}, 32'h0);
    expect_ev(K_READY, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1);

    clks(50);
    check("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
